// File: rtl/ula_ctrl_seq.sv
// ---------------------------------------------------------------------------
// ula_ctrl_seq
// Registered ALU control unit with a multiply/divide sequencer.
//
// Decodes ALUOp/funct into a ULA operation code plus side-band flags, one
// cycle after an instruction is accepted. It also launches multi-cycle
// MULT/MULTU/DIV/DIVU operations, tracks them with a down-counter, and
// stalls HI/LO consumers (MFHI/MFLO) and new multiply/divides while one is
// still in flight.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   valid_in      ALUOp/funct carry a decoded instruction this cycle
//   ALUOp, funct  operation class and instruction bits [5:0]
//   stall         combinational; instruction not accepted, hold it upstream
//   ALUControl    registered ULA operation code (held when nothing accepted)
//   ctrl_valid    registered; decode outputs describe an accepted instruction
//   shift_var     variable shift (SLLV/SRLV/SRAV)
//   jr            R-type JR
//   hilo_rd       01 = MFHI, 10 = MFLO, 00 otherwise
//   illegal       unknown ALUOp or R-type funct
//   md_start      one-cycle pulse, multiply/divide launched
//   md_op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held until next launch
//   md_busy       multiply/divide in progress
//   md_done       one-cycle pulse, HI/LO valid
// ---------------------------------------------------------------------------
module ula_ctrl_seq #(
   parameter int ALUOP_W   = 4,
   parameter int FUNCT_W   = 6,
   parameter int CTRL_W    = 4,
   parameter int MD_CYCLES = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               valid_in,
   input  logic [ALUOP_W-1:0] ALUOp,
   input  logic [FUNCT_W-1:0] funct,
   output logic               stall,
   output logic [CTRL_W-1:0]  ALUControl,
   output logic               ctrl_valid,
   output logic               shift_var,
   output logic               jr,
   output logic [1:0]         hilo_rd,
   output logic               illegal,
   output logic               md_start,
   output logic [1:0]         md_op,
   output logic               md_busy,
   output logic               md_done
);

   localparam int CNT_W = $clog2(MD_CYCLES + 1);

   localparam logic [CTRL_W-1:0] ULA_ADD  = CTRL_W'(0);
   localparam logic [CTRL_W-1:0] ULA_SUB  = CTRL_W'(1);
   localparam logic [CTRL_W-1:0] ULA_AND  = CTRL_W'(2);
   localparam logic [CTRL_W-1:0] ULA_OR   = CTRL_W'(3);
   localparam logic [CTRL_W-1:0] ULA_XOR  = CTRL_W'(4);
   localparam logic [CTRL_W-1:0] ULA_NOR  = CTRL_W'(5);
   localparam logic [CTRL_W-1:0] ULA_SLT  = CTRL_W'(6);
   localparam logic [CTRL_W-1:0] ULA_SLTU = CTRL_W'(7);
   localparam logic [CTRL_W-1:0] ULA_SLL  = CTRL_W'(8);
   localparam logic [CTRL_W-1:0] ULA_SRL  = CTRL_W'(9);
   localparam logic [CTRL_W-1:0] ULA_SRA  = CTRL_W'(10);
   localparam logic [CTRL_W-1:0] ULA_LUI  = CTRL_W'(11);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [5:0]        fn;
   logic              rtype;
   logic              hilo_hazard;
   logic              accept;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_shift_var;
   logic              dec_jr;
   logic [1:0]        dec_hilo;
   logic              dec_illegal;
   logic              dec_md;

   assign fn    = funct[5:0];
   assign rtype = (ALUOp == '0);

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      dec_ctrl      = ULA_ADD;
      dec_shift_var = 1'b0;
      dec_jr        = 1'b0;
      dec_hilo      = 2'b00;
      dec_illegal   = 1'b0;
      dec_md        = 1'b0;
      if (rtype) begin
         case (fn)
            6'h20: dec_ctrl = ULA_ADD;
            6'h22: dec_ctrl = ULA_SUB;
            6'h24: dec_ctrl = ULA_AND;
            6'h25: dec_ctrl = ULA_OR;
            6'h26: dec_ctrl = ULA_XOR;
            6'h27: dec_ctrl = ULA_NOR;
            6'h2A: dec_ctrl = ULA_SLT;
            6'h2B: dec_ctrl = ULA_SLTU;
            6'h00: dec_ctrl = ULA_SLL;
            6'h04: begin dec_ctrl = ULA_SLL; dec_shift_var = 1'b1; end
            6'h02: dec_ctrl = ULA_SRL;
            6'h06: begin dec_ctrl = ULA_SRL; dec_shift_var = 1'b1; end
            6'h03: dec_ctrl = ULA_SRA;
            6'h07: begin dec_ctrl = ULA_SRA; dec_shift_var = 1'b1; end
            6'h08: dec_jr   = 1'b1;
            6'h10: dec_hilo = 2'b01;
            6'h12: dec_hilo = 2'b10;
            6'h18, 6'h19, 6'h1A, 6'h1B: dec_md = 1'b1;
            default: dec_illegal = 1'b1;
         endcase
      end else begin
         case (ALUOp)
            ALUOP_W'(1), ALUOP_W'(10), ALUOP_W'(11),
            ALUOP_W'(12), ALUOP_W'(13):   dec_ctrl = ULA_ADD;
            ALUOP_W'(2):                  dec_ctrl = ULA_AND;
            ALUOP_W'(3):                  dec_ctrl = ULA_OR;
            ALUOP_W'(4):                  dec_ctrl = ULA_XOR;
            ALUOP_W'(5), ALUOP_W'(6):     dec_ctrl = ULA_SUB;
            ALUOP_W'(7):                  dec_ctrl = ULA_SLT;
            ALUOP_W'(8):                  dec_ctrl = ULA_SLTU;
            ALUOP_W'(9):                  dec_ctrl = ULA_LUI;
            default:                      dec_illegal = 1'b1;
         endcase
      end
   end

   // Anything that reads HI/LO or would relaunch the unit must wait while
   // an operation is in flight; everything else flows through.
   assign hilo_hazard = rtype & ((fn == 6'h10) | (fn == 6'h12) | (fn[5:2] == 4'b0110));
   assign stall       = valid_in & (state_q == BUSY) & hilo_hazard;
   assign accept      = valid_in & ~stall;

   // ---------------------------------------------------------------------
   // Sequencer FSM: state register
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Sequencer FSM: next state
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept && dec_md) begin
               state_d = BUSY;
               count_d = CNT_W'(MD_CYCLES - 1);
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // count is MD_CYCLES-1 on entry, so BUSY lasts MD_CYCLES cycles.
            if (count_q == '0) state_d = DONE;
            else               count_d = count_q - CNT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer FSM: outputs
   always_comb begin
      md_busy = (state_q == BUSY);
      md_done = (state_q == DONE);
   end

   // ---------------------------------------------------------------------
   // Registered decode outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALUControl <= ULA_ADD;
         ctrl_valid <= 1'b0;
         shift_var  <= 1'b0;
         jr         <= 1'b0;
         hilo_rd    <= 2'b00;
         illegal    <= 1'b0;
         md_start   <= 1'b0;
         md_op      <= 2'b00;
      end else begin
         // Flags describe only the instruction accepted on this edge; the
         // operation code is sticky so the ULA keeps a stable selection.
         ctrl_valid <= accept;
         shift_var  <= accept & dec_shift_var;
         jr         <= accept & dec_jr;
         hilo_rd    <= accept ? dec_hilo : 2'b00;
         illegal    <= accept & dec_illegal;
         md_start   <= accept & dec_md;
         if (accept)          ALUControl <= dec_ctrl;
         if (accept && dec_md) md_op     <= fn[1:0];
      end
   end

endmodule

// File: tb/tb_ula_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_ctrl_seq
// Self-checking bench for ula_ctrl_seq with MD_CYCLES = 4. Expected decode
// results are queued when an instruction is driven and compared when the
// DUT raises ctrl_valid; sequencer timing and stall are checked directly.
// ---------------------------------------------------------------------------
module tb_ula_ctrl_seq;

   localparam int MDC = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid_in;
   logic [3:0] ALUOp;
   logic [5:0] funct;
   logic       stall;
   logic [3:0] ALUControl;
   logic       ctrl_valid, shift_var, jr, illegal, md_start, md_busy, md_done;
   logic [1:0] hilo_rd, md_op;

   ula_ctrl_seq #(
      .ALUOP_W(4), .FUNCT_W(6), .CTRL_W(4), .MD_CYCLES(MDC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALUOp(ALUOp),
      .funct(funct), .stall(stall), .ALUControl(ALUControl),
      .ctrl_valid(ctrl_valid), .shift_var(shift_var), .jr(jr),
      .hilo_rd(hilo_rd), .illegal(illegal), .md_start(md_start),
      .md_op(md_op), .md_busy(md_busy), .md_done(md_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] ctrl;
      logic       sv;
      logic       jr;
      logic [1:0] hl;
      logic       ill;
      logic       ms;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [3:0] last_ctrl = 4'd0;
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference decode table.
   function automatic exp_t model(input int a, input int f);
      exp_t r;
      r = '0;
      if (a == 0) begin
         case (f)
            'h20: r.ctrl = 0;
            'h22: r.ctrl = 1;
            'h24: r.ctrl = 2;
            'h25: r.ctrl = 3;
            'h26: r.ctrl = 4;
            'h27: r.ctrl = 5;
            'h2A: r.ctrl = 6;
            'h2B: r.ctrl = 7;
            'h00: r.ctrl = 8;
            'h04: begin r.ctrl = 8;  r.sv = 1; end
            'h02: r.ctrl = 9;
            'h06: begin r.ctrl = 9;  r.sv = 1; end
            'h03: r.ctrl = 10;
            'h07: begin r.ctrl = 10; r.sv = 1; end
            'h08: r.jr = 1;
            'h10: r.hl = 2'b01;
            'h12: r.hl = 2'b10;
            'h18, 'h19, 'h1A, 'h1B: r.ms = 1;
            default: r.ill = 1;
         endcase
      end else begin
         case (a)
            1, 10, 11, 12, 13: r.ctrl = 0;
            2: r.ctrl = 2;
            3: r.ctrl = 3;
            4: r.ctrl = 4;
            5, 6: r.ctrl = 1;
            7: r.ctrl = 6;
            8: r.ctrl = 7;
            9: r.ctrl = 11;
            default: r.ill = 1;
         endcase
      end
      return r;
   endfunction

   // Scoreboard monitor: registered outputs are sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_ctrl = 4'd0;
      end else if (ctrl_valid) begin
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("alu_ctrl",  32'(ALUControl), 32'(e.ctrl));
            check("shift_var", 32'(shift_var),  32'(e.sv));
            check("jr",        32'(jr),         32'(e.jr));
            check("hilo_rd",   32'(hilo_rd),    32'(e.hl));
            check("illegal",   32'(illegal),    32'(e.ill));
            check("md_start",  32'(md_start),   32'(e.ms));
            last_ctrl = e.ctrl;
         end
      end else begin
         check("hold_ctrl",  32'(ALUControl), 32'(last_ctrl));
         check("idle_flags", 32'({shift_var, jr, hilo_rd, illegal, md_start}), 32'd0);
      end
   end

   // One cycle: drive at posedge+1, check stall, queue the expectation if
   // the instruction should be accepted, return at the next posedge+1.
   task automatic cyc(input int v, input int a, input int f, input int exp_stall);
      valid_in = v[0];
      ALUOp    = a[3:0];
      funct    = f[5:0];
      #1;
      check("stall", 32'(stall), 32'(exp_stall));
      if (v != 0 && exp_stall == 0) sb.push_back(model(a, f));
      @(posedge clk);
      #1;
   endtask

   task automatic chk_md(input int b, input int d);
      check("md_busy", 32'(md_busy), 32'(b));
      check("md_done", 32'(md_done), 32'(d));
   endtask

   task automatic chk_all_zero();
      check("rst_outs", 32'({ALUControl, ctrl_valid, shift_var, jr, hilo_rd,
                              illegal, md_start, md_op, md_busy, md_done}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      valid_in = 1'b0;
      ALUOp    = 4'd0;
      funct    = 6'd0;
      @(posedge clk);
      #1;
      chk_all_zero();
      check("rst_stall", 32'(stall), 32'd0);
      rst_n = 1'b1;

      // ALUOp sweep (non-R-type; funct is don't-care).
      for (int a = 1; a < 16; a++) cyc(1, a, $urandom_range(0, 63), 0);
      cyc(0, 0, 0, 0);

      // R-type funct sweep; multiply/divides get drained before moving on.
      for (int f = 0; f < 64; f++) begin
         cyc(1, 0, f, 0);
         if (f >= 'h18 && f <= 'h1B) repeat (MDC) cyc(0, 0, 0, 0);
      end
      cyc(0, 0, 0, 0);

      // Asynchronous reset mid-cycle with a non-zero operation code held.
      cyc(1, 9, 0, 0);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk_all_zero();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_all_zero();

      // MULTU with hazard: ADD flows at k+2, MFLO stalls until DONE.
      cyc(1, 0, 'h19, 0);                 // accepted at edge k
      chk_md(1, 0);                       // k+1
      check("md_op_multu", 32'(md_op), 32'd1);
      cyc(0, 0, 0, 0);
      chk_md(1, 0);                       // k+2
      cyc(1, 0, 'h20, 0);
      chk_md(1, 0);                       // k+3
      cyc(1, 0, 'h12, 1);
      chk_md(1, 0);                       // k+4
      cyc(1, 0, 'h12, 1);
      chk_md(0, 1);                       // k+5 DONE
      cyc(1, 0, 'h12, 0);
      chk_md(0, 0);                       // k+6 IDLE
      cyc(0, 0, 0, 0);

      // Back-to-back: MULT, then DIV launched from the DONE cycle.
      cyc(1, 0, 'h18, 0);
      for (int i = 0; i < MDC; i++) begin
         chk_md(1, 0);
         cyc(0, 0, 0, 0);
      end
      chk_md(0, 1);
      check("md_op_mult", 32'(md_op), 32'd0);
      cyc(1, 0, 'h1A, 0);
      chk_md(1, 0);
      check("md_op_div", 32'(md_op), 32'd2);
      for (int i = 1; i < MDC; i++) begin
         cyc(0, 0, 0, 0);
         chk_md(1, 0);
      end
      cyc(0, 0, 0, 0);
      chk_md(0, 1);
      cyc(0, 0, 0, 0);
      chk_md(0, 0);

      // Reset during BUSY aborts with no md_done afterwards.
      cyc(1, 0, 'h1B, 0);
      cyc(0, 0, 0, 0);
      chk_md(1, 0);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk_all_zero();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < MDC + 2; i++) begin
         chk_md(0, 0);
         cyc(0, 0, 0, 0);
      end

      // Fresh MULT after reset runs the full MD_CYCLES.
      cyc(1, 0, 'h18, 0);
      for (int i = 0; i < MDC; i++) begin
         chk_md(1, 0);
         cyc(0, 0, 0, 0);
      end
      chk_md(0, 1);
      cyc(0, 0, 0, 0);
      chk_md(0, 0);

      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ula_ctrl_seq.md
# ula_ctrl_seq

Registered, parametrised ALU control unit with a multiply/divide sequencer. It sits between the central control unit and the ULA/multiply-divide datapath. It decodes ALUOp/funct into the ULA operation code and side-band flags one cycle after acceptance. It also launches and tracks multi-cycle MULT/MULTU/DIV/DIVU operations, and stalls the front end on HI/LO hazards.

## Interface
- ALUOP_W, 4: width of ALUOp.
- FUNCT_W, 6: width of funct.
- CTRL_W, 4: width of ALUControl; must be ≥4.
- MD_CYCLES, 32: busy cycles per multiply/divide; legal range ≥1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset. Asserts asynchronously and is released synchronously by the surrounding design.
- valid_in  in  1  ALUOp/funct hold a decoded instruction this cycle.
- ALUOp  in  ALUOP_W  operation class from the central control unit.
- funct  in  FUNCT_W  instruction bits [5:0].
- stall  out  1  combinational; instruction not accepted this cycle, so upstream must hold it.
- ALUControl  out  CTRL_W  registered ULA operation code.
- ctrl_valid  out  1  registered; outputs describe an accepted instruction.
- shift_var  out  1  SLLV/SRLV/SRAV (shift amount comes from rs).
- jr  out  1  funct 0x08 under R-type.
- hilo_rd  out  2  01 = MFHI (0x10), 10 = MFLO (0x12), 00 otherwise.
- illegal  out  1  unknown ALUOp or R-type funct.
- md_start  out  1  one-cycle pulse; multiply/divide launched.
- md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held until the next launch.
- md_busy  out  1  multiply/divide in progress.
- md_done  out  1  one-cycle pulse; HI/LO valid this cycle.

## Operation
- **ULA codes:** ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, LUI 11. Codes are zero-extended to CTRL_W.
- **ALUOp mapping:**
  - 0 R-type; 1 ADDI, 10 LW, 11 SW → ADD.
  - 2 ANDI → AND; 3 ORI → OR; 4 XORI → XOR.
  - 5 BEQ, 6 BNE → SUB.
  - 7 SLTI → SLT; 8 SLTIU → SLTU; 9 LUI → LUI.
  - 12 J, 13 JAL → ADD.
  - Any other value → ADD with illegal=1.
- **R-type funct mapping:**
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - 0x00/0x04 SLL, 0x02/0x06 SRL, 0x03/0x07 SRA; shift_var=1 for 0x04/0x06/0x07.
  - 0x08 JR, 0x10 MFHI, 0x12 MFLO, and 0x18–0x1B multiply/divide → ADD plus the matching flag.
  - Any other funct → ADD with illegal=1.
- **Acceptance:** accept = valid_in & ~stall. On accept, all decode outputs register and ctrl_valid=1 next cycle. Without accept: ctrl_valid=0, flags (shift_var, jr, hilo_rd, illegal, md_start) clear to 0, ALUControl holds.
- **Hazard:** stall = valid_in & (state==BUSY) & R-type & funct ∈ {0x10, 0x12, 0x18–0x1B}. Every other instruction is accepted while BUSY.
- **FSM states:** IDLE, BUSY, DONE.
  - IDLE/DONE → BUSY on an accepted multiply/divide. At that edge: count ← MD_CYCLES−1, md_start=1, md_op ← funct[1:0].
  - BUSY: count decrements each edge. When count==0 → DONE, with md_done=1.
  - DONE → IDLE on the next edge unless a multiply/divide is accepted. Back-to-back launch from DONE is legal.
  - Counter width is $clog2(MD_CYCLES+1); it never wraps below 0.
- **Outputs by state:** md_busy = (state==BUSY). md_done = (state==DONE).
- **Reset:** any reset, including mid-BUSY, aborts the operation. State → IDLE, count=0, every output 0 (ALUControl=ADD, md_op=00). No md_done follows.

## Timing
- Decode latency: 1 cycle from the accepting edge to registered outputs.
- Multiply/divide: md_start and md_busy rise together in the cycle after acceptance. md_busy stays high for exactly MD_CYCLES cycles, then md_done for 1 cycle.
- MFHI/MFLO issued in the DONE cycle is accepted without stall.
- stall is combinational from valid_in/ALUOp/funct/state; there is no combinational path to registered outputs.

## Test plan
- **Reset:** assert rst_n=0 mid-cycle → all outputs 0 immediately. After release, IDLE with stall=0.
- **Decode sweep:** every ALUOp 0–15, plus R-type with every funct 0x00–0x3F → ALUControl/flags match the mapping one cycle later. Examples: ALUOp=5 → 1; funct 0x27 → 5; funct 0x06 → 9 with shift_var=1; funct 0x3F → illegal=1.
- **Multiply/divide sequence (MD_CYCLES=4):** MULTU accepted at edge k → md_start=1, md_op=01, md_busy=1 for cycles k+1..k+4, md_done=1 at k+5, IDLE at k+6.
- **Hazard:** MFLO presented at k+2 → stall=1 through k+4, accepted in the DONE cycle. ADD presented at k+2 → accepted with no stall.
- **Back-to-back:** DIV presented in the DONE cycle → accepted; BUSY again with md_op=10, no IDLE gap.
- **Reset mid-operation:** reset asserted during BUSY → md_busy=0 at once, no md_done pulse. A new MULT after release takes the full MD_CYCLES.
